// File: rtl/aes_key_mem_if.sv
// Port bundle for aes_key_mem: expansion start/key inputs, round-key read port
// and the word path to the shared S-box.
interface aes_key_mem_if;
  logic         init;
  logic [255:0] key;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         ready;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;

  modport master (
    output init, key, keylen, round, new_sboxw,
    input  round_key, ready, sboxw
  );

  modport slave (
    input  init, key, keylen, round, new_sboxw,
    output round_key, ready, sboxw
  );
endinterface

// File: rtl/aes_key_mem.sv
// AES round-key expansion and store, one round key per cycle via the shared S-box.
// Define AES_KEY256_EN to add the AES-256 path; otherwise only AES-128 exists.
module aes_key_mem #(
`ifdef AES_KEY256_EN
  parameter int NUM_RKEYS = 15
`else
  parameter int NUM_RKEYS = 11
`endif
) (
  input  logic         clock,
  input  logic         reset,
  aes_key_mem_if.slave bus
);

  typedef enum logic [1:0] {IDLE, INIT, GENERATE, DONE} state_e;

  state_e       state_q;
  logic         ready_q;
  logic         key_valid_q;
  logic [3:0]   ctr_q;
  logic [7:0]   rcon_q;
  logic [127:0] key_hi_q;
  logic [127:0] prev_q;
  logic [127:0] rk_q [NUM_RKEYS];

  logic         is_256;
  logic [3:0]   last_idx;
  logic         sub_only;
  logic [127:0] base;
  logic [31:0]  t, w0, w1, w2, w3;
  logic [127:0] new_rk_d;
  logic [7:0]   rcon_d;

`ifdef AES_KEY256_EN
  logic         keylen_q;
  logic [127:0] key_lo_q;
  logic [127:0] prev2_q;
  assign is_256 = keylen_q;
`else
  logic unused_key_inputs;
  assign unused_key_inputs = ^{bus.keylen, bus.key[127:0]};
  assign is_256 = 1'b0;
`endif

  assign last_idx = is_256 ? 4'd14 : 4'd10;

  // Next round key from the S-box result of the previous key's last word.
  always_comb begin
`ifdef AES_KEY256_EN
    base     = keylen_q ? prev2_q : prev_q;
    sub_only = keylen_q & ctr_q[0];
`else
    base     = prev_q;
    sub_only = 1'b0;
`endif
    t = sub_only ? bus.new_sboxw
                 : ({bus.new_sboxw[23:0], bus.new_sboxw[31:24]} ^ {rcon_q, 24'h0});
    w0       = base[127:96] ^ t;
    w1       = base[95:64]  ^ w0;
    w2       = base[63:32]  ^ w1;
    w3       = base[31:0]   ^ w2;
    new_rk_d = {w0, w1, w2, w3};
    rcon_d   = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      key_valid_q <= 1'b0;
      ctr_q       <= 4'd0;
      rcon_q      <= 8'h8d;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (bus.init && ready_q) begin
            state_q     <= INIT;
            ready_q     <= 1'b0;
            key_valid_q <= 1'b0;
            key_hi_q    <= bus.key[255:128];
`ifdef AES_KEY256_EN
            key_lo_q    <= bus.key[127:0];
            keylen_q    <= bus.keylen;
`endif
          end
        end
        INIT: begin
          rcon_q  <= 8'h01;
          state_q <= GENERATE;
`ifdef AES_KEY256_EN
          prev2_q <= key_hi_q;
          prev_q  <= keylen_q ? key_lo_q : key_hi_q;
          ctr_q   <= keylen_q ? 4'd2 : 4'd1;
`else
          prev_q  <= key_hi_q;
          ctr_q   <= 4'd1;
`endif
        end
        GENERATE: begin
`ifdef AES_KEY256_EN
          prev2_q <= prev_q;
`endif
          prev_q <= new_rk_d;
          if (!sub_only) rcon_q <= rcon_d;
          if (ctr_q == last_idx) begin
            state_q     <= DONE;
            ready_q     <= 1'b1;
            key_valid_q <= 1'b1;
          end else begin
            ctr_q <= ctr_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the key store is a plain memory with no reset; key_valid_q alone guards reads.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_q == INIT) begin
        rk_q[0] <= key_hi_q;
`ifdef AES_KEY256_EN
        if (keylen_q) rk_q[1] <= key_lo_q;
`endif
      end else if (state_q == GENERATE) begin
        rk_q[ctr_q] <= new_rk_d;
      end
    end
  end

  // NOTE: default assignment first so the combinational read never infers a latch.
  always_comb begin
    bus.round_key = '0;
    if (key_valid_q && (bus.round <= last_idx)) bus.round_key = rk_q[bus.round];
  end

  assign bus.ready = ready_q;
  assign bus.sboxw = (state_q == GENERATE) ? prev_q[31:0] : 32'h0;

endmodule

// File: tb/tb_aes_key_mem.sv
// Scoreboard bench for aes_key_mem: FIPS-197 vectors plus random keys against a
// word-level key-schedule model; honours AES_KEY256_EN like the design.
module tb_aes_key_mem;

  logic clock;
  logic reset;
  aes_key_mem_if bus ();

  aes_key_mem dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [2047:0] sbox_flat = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return sbox_flat[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

  // The shared S-box the top level would mux in.
  assign bus.new_sboxw = sub_word(bus.sboxw);

  // ---------------- reference model: FIPS-197 word schedule ----------------
  logic [31:0] mw [60];
  logic        mdl_valid;
  int          mdl_last;

  task automatic expand(input logic [255:0] key, input logic k256);
    int          nk;
    int          total;
    logic [31:0] temp;
    logic [7:0]  rc;
    nk    = k256 ? 8 : 4;
    total = k256 ? 60 : 44;
    rc    = 8'h01;
    for (int i = 0; i < nk; i++) mw[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < total; i++) begin
      temp = mw[i - 1];
      if (i % nk == 0) begin
        temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
        rc   = (rc[7] ? 8'h1b : 8'h00) ^ {rc[6:0], 1'b0};
      end else if (nk == 8 && i % nk == 4) begin
        temp = sub_word(temp);
      end
      mw[i] = mw[i - nk] ^ temp;
    end
    mdl_last = k256 ? 14 : 10;
  endtask

  function automatic logic [127:0] model_rk(input int r);
    if (!mdl_valid || r > mdl_last) return 128'h0;
    return {mw[4 * r], mw[4 * r + 1], mw[4 * r + 2], mw[4 * r + 3]};
  endfunction

  // ---------------- scoreboard ----------------
  typedef enum {CK_RK, CK_READY, CK_SBOXW} ck_e;
  typedef struct {
    ck_e          kind;
    logic [127:0] exp;
    string        name;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic void push(input ck_e kind, input logic [127:0] exp, input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endfunction

  always @(negedge clock) begin
    exp_t         e;
    logic [127:0] act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        CK_RK:    act = bus.round_key;
        CK_READY: act = {127'h0, bus.ready};
        default:  act = {96'h0, bus.sboxw};
      endcase
      vectors++;
      if (act !== e.exp) begin
        miscompares++;
        $display("FAIL %s (round=%0d) got=%h want=%h", e.name, bus.round, act, e.exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(input int budget);
    for (int i = 0; i < budget && bus.ready !== 1'b1; i++) tick();
    if (bus.ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout got=%b want=1", bus.ready);
    end
  endtask

  task automatic check_all_rounds();
    for (int r = 0; r < 16; r++) begin
      bus.round = 4'(r);
      push(CK_RK, model_rk(r), "round_key_model");
      tick();
    end
  endtask

  task automatic check_const(input int r, input logic [127:0] exp, input string name);
    bus.round = 4'(r);
    push(CK_RK, exp, name);
    tick();
  endtask

  // Drives one expansion; glitch_at/reset_at name a cycle after acceptance (or -1).
  task automatic run_expansion(input logic [255:0] key, input logic keylen,
                               input int glitch_at, input int reset_at);
    logic k256;
    int   lat;
`ifdef AES_KEY256_EN
    k256 = keylen;
`else
    k256 = 1'b0;
`endif
    lat = k256 ? 15 : 12;
    wait_ready(40);
    bus.init   = 1'b1;
    bus.key    = key;
    bus.keylen = keylen;
    push(CK_READY, 128'h1, "ready_at_accept");
    tick();
    bus.init   = 1'b0;
    bus.key    = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
    bus.keylen = 1'($urandom_range(0, 1));
    mdl_valid  = 1'b0;
    expand(key, k256);
    for (int c = 1; c < lat; c++) begin
      push(CK_READY, 128'h0, "ready_busy");
      bus.round = 4'($urandom_range(0, 15));
      push(CK_RK, 128'h0, "round_key_busy");
      if (c >= 2) push(CK_SBOXW, {96'h0, mw[4 * (c - 1 + (k256 ? 1 : 0)) - 1]}, "sboxw_gen");
      else        push(CK_SBOXW, 128'h0, "sboxw_init");
      if (c == glitch_at) bus.init = 1'b1;
      if (c == reset_at)  reset = 1'b1;
      tick();
      bus.init = 1'b0;
      if (c == reset_at) begin
        reset = 1'b0;
        for (int r = 0; r < 16; r++) begin
          push(CK_READY, 128'h1, "ready_after_reset");
          push(CK_SBOXW, 128'h0, "sboxw_after_reset");
          bus.round = 4'(r);
          push(CK_RK, 128'h0, "round_key_after_reset");
          tick();
        end
        return;
      end
    end
    mdl_valid = 1'b1;
    push(CK_READY, 128'h1, "ready_done");
  endtask

  localparam logic [255:0] KEY_A1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};

  task automatic check_a1();
    check_const(0,  128'h2b7e151628aed2a6abf7158809cf4f3c, "a1_rk0");
    check_const(1,  128'ha0fafe1788542cb123a339392a6c7605, "a1_rk1");
    check_const(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "a1_rk10");
    check_const(11, 128'h0, "a1_rk11");
  endtask

  initial begin
    reset      = 1'b1;
    bus.init   = 1'b0;
    bus.key    = '0;
    bus.keylen = 1'b0;
    bus.round  = 4'd0;
    mdl_valid  = 1'b0;
    mdl_last   = 10;
    tick();
    tick();
    reset = 1'b0;
    push(CK_READY, 128'h1, "ready_reset");
    push(CK_SBOXW, 128'h0, "sboxw_reset");
    push(CK_RK, 128'h0, "round_key_reset");
    tick();

    // FIPS-197 A.1, with first-cycle S-box word check
    run_expansion(KEY_A1, 1'b0, -1, -1);
    push(CK_SBOXW, 128'h0, "sboxw_idle");
    check_all_rounds();
    check_a1();

    // Back-to-back: old keys hidden during the run, new ones after
    run_expansion(KEY_C1, 1'b0, -1, -1);
    check_const(10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "c1_rk10");
    check_all_rounds();

    // init pulse while busy is ignored
    run_expansion(KEY_A1, 1'b0, 5, -1);
    check_a1();

    // reset mid-expansion, then a clean run
    run_expansion(KEY_A1, 1'b0, -1, 6);
    mdl_valid = 1'b0;
    run_expansion(KEY_A1, 1'b0, -1, -1);
    check_a1();

    // reset and init together: reset wins, block stays idle with no valid keys
    reset    = 1'b1;
    bus.init = 1'b1;
    tick();
    reset     = 1'b0;
    bus.init  = 1'b0;
    mdl_valid = 1'b0;
    bus.round = 4'd0;
    push(CK_READY, 128'h1, "ready_reset_init");
    push(CK_RK, 128'h0, "round_key_reset_init");
    tick();
    push(CK_READY, 128'h1, "ready_stays_idle");
    push(CK_SBOXW, 128'h0, "sboxw_stays_idle");
    tick();

`ifdef AES_KEY256_EN
    // FIPS-197 A.3
    run_expansion(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                  1'b1, -1, -1);
    check_const(14, 128'hfe4890d1e6188d0b046df344706c631e, "a3_rk14");
    check_const(1,  128'h1f352c073b6108d72d9810a30914dff4, "a3_rk1");
    check_all_rounds();
`endif

    // Random keys and key lengths
    for (int n = 0; n < 8; n++) begin
      run_expansion({$urandom(), $urandom(), $urandom(), $urandom(),
                     $urandom(), $urandom(), $urandom(), $urandom()},
                    1'($urandom_range(0, 1)), -1, -1);
      check_all_rounds();
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "simulation watchdog expired");
  end

endmodule
